// File: rtl/frame_stream_egress.sv
// Buffers the backpressure-free coprocessor output stream in a FIFO and re-emits it as an
// AXI4-Stream master. On overflow a frame is truncated or dropped, so frames are never merged.
module frame_stream_egress #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          masterClock,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic                          dataInAvailable,
    input  logic                          endOfFrameIn,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic [CNT_WIDTH-1:0]          frameCount,
    output logic [CNT_WIDTH-1:0]          lastFrameLength,
    output logic                          overflow,
    input  logic                          overflowClear
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]        LVL_LAST = LW'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;
    logic [CNT_WIDTH-1:0]  r_last_len;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_push_eof;
    logic                  w_ovf_set;
    logic [DATA_WIDTH:0]   w_head;

    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & m_axis_tready;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept/drop decisions look only at the level before this edge; a concurrent pop never
    // makes room for the incoming word.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_eof  = endOfFrameIn;
        w_ovf_set   = 1'b0;
        if (dataInAvailable) begin
            unique case (r_state)
                ST_ACCEPT: begin
                    if (r_level < LVL_LAST) begin
                        w_push = 1'b1;
                    end else if (r_level == LVL_LAST) begin
                        w_push = 1'b1;
                        if (!endOfFrameIn) begin
                            w_push_eof  = 1'b1;
                            w_ovf_set   = 1'b1;
                            w_state_nxt = ST_DISCARD;
                        end
                    end else begin
                        w_ovf_set = 1'b1;
                        if (!endOfFrameIn) begin
                            w_state_nxt = ST_DISCARD;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (endOfFrameIn) begin
                        w_state_nxt = ST_ACCEPT;
                    end
                end
                default: w_state_nxt = ST_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge masterClock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_push_eof, dataIn};
        end
    end

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (overflowClear) begin
            r_overflow <= 1'b0;
        end
    end

    // Beat counter saturates with the length it feeds so very long frames report all-ones.
    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_beat_cnt  <= '0;
            r_frame_cnt <= '0;
            r_last_len  <= '0;
        end else if (w_pop) begin
            if (w_head[DATA_WIDTH]) begin
                r_last_len  <= (r_beat_cnt == CNT_MAX) ? CNT_MAX : r_beat_cnt + CNT_WIDTH'(1);
                r_beat_cnt  <= '0;
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            end else if (r_beat_cnt != CNT_MAX) begin
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign m_axis_tvalid   = w_valid;
    assign m_axis_tdata    = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tlast    = w_valid ? w_head[DATA_WIDTH] : 1'b0;
    assign fifoLevel       = r_level;
    assign frameCount      = r_frame_cnt;
    assign lastFrameLength = r_last_len;
    assign overflow        = r_overflow;

endmodule
